// File: rtl/fifo_sc_pkg.sv
// Shared definitions for the single-clock register-array FIFO family.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package fifo_sc_pkg;

  // Default geometry of a single-clock FIFO instance
  localparam int FIFO_SC_DATA_WIDTH = 16;
  localparam int FIFO_SC_ADDR_WIDTH = 4;

  // Number of entries for a given address width
  function automatic int fifo_sc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy / threshold count for the default geometry (one extra bit so DEPTH fits)
  typedef logic [FIFO_SC_ADDR_WIDTH:0] fifo_sc_cnt_t;

endpackage

// File: rtl/fifo_sc_flag_gen.sv
// Occupancy and status flag generator from extended (ADDR_WIDTH+1)-bit pointers.
// Latency: purely combinational, flags follow pointers and thresholds in the same cycle.
// Backpressure: none; full/empty are consumed by the owning FIFO to gate accesses.
module fifo_sc_flag_gen #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH:0] wrptr,
  input  logic [ADDR_WIDTH:0] rdptr,
  input  logic [ADDR_WIDTH:0] af_thresh,
  input  logic [ADDR_WIDTH:0] ae_thresh,
  output logic [ADDR_WIDTH:0] depth,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full
);

  logic [ADDR_WIDTH:0] depth_w;

  // Modular difference of the extended pointers gives the full 0..DEPTH range
  assign depth_w = wrptr - rdptr;
  assign depth   = depth_w;

  // Equal pointers mean empty; same slot but opposite lap bit means full
  assign empty = (wrptr == rdptr);
  assign full  = (wrptr[ADDR_WIDTH-1:0] == rdptr[ADDR_WIDTH-1:0]) &&
                 (wrptr[ADDR_WIDTH] != rdptr[ADDR_WIDTH]);

  // Unsigned compares: af_thresh=0 always trips, ae_thresh>=DEPTH always trips
  assign almost_full  = (depth_w >= af_thresh);
  assign almost_empty = (depth_w <= ae_thresh);

endmodule

// File: rtl/fifo_reg_array_sc_prog.sv
// Single-clock register-array FIFO with occupancy count, programmable thresholds and write-through-on-full.
// Latency: written word visible on show-ahead data_out one edge after the write; flags combinational from pointers.
// Backpressure: writes when full are dropped unless a read happens in the same cycle; sticky errors need FIFO_SC_ERR_FLAGS_EN.
module fifo_reg_array_sc_prog
  import fifo_sc_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_SC_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_SC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_sc_depth(ADDR_WIDTH);

  logic [ADDR_WIDTH:0]   wrptr;
  logic [ADDR_WIDTH:0]   rdptr;
  logic [DATA_WIDTH-1:0] reg_array [DEPTH];
  logic                  renq;
  logic                  wenq;

  // A read never bypasses a same-cycle write into an empty FIFO;
  // a write into a full FIFO is accepted only when a real read frees the slot.
  assign renq = ren & ~empty;
  assign wenq = wen & (~full | renq);

  // Pointer registers; reset discards all contents without touching the array
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrptr <= '0;
      rdptr <= '0;
    end else begin
      if (wenq) wrptr <= wrptr + 1'b1;
      if (renq) rdptr <= rdptr + 1'b1;
    end
  end

  // Storage write; the array is deliberately not reset
  always_ff @(posedge clk) begin
    if (wenq) reg_array[wrptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  // Show-ahead head word; stale while empty
  assign data_out = reg_array[rdptr[ADDR_WIDTH-1:0]];

  fifo_sc_flag_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_flag_gen (
    .wrptr        (wrptr),
    .rdptr        (rdptr),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .depth        (depth),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
  );

`ifdef FIFO_SC_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wen & ~wenq)  overflow_q <= 1'b1;
      else if (err_clr) overflow_q <= 1'b0;
      if (ren & ~renq)  underflow_q <= 1'b1;
      else if (err_clr) underflow_q <= 1'b0;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;

  // Error reporting compiled out: flags tied low, clear input has no effect
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reg_array_sc_prog.sv
module tb_fifo_reg_array_sc_prog;
  import fifo_sc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

`ifdef FIFO_SC_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wen;
  logic          ren;
  logic [DW-1:0] data_in;
  fifo_sc_cnt_t  af_thresh;
  fifo_sc_cnt_t  ae_thresh;
  logic          err_clr;
  logic [DW-1:0] data_out;
  fifo_sc_cnt_t  depth;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_reg_array_sc_prog #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wen          (wen),
    .ren          (ren),
    .data_in      (data_in),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .depth        (depth),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // One clock with the given request, then return to idle; leaves time at posedge+1
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wen = w; ren = r; data_in = d;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic test_reset();
    af_thresh = 5'd0; ae_thresh = 5'd0;
    #1;
    checks++; if (depth !== 5'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL reset_af_thr0: got %b want 1", almost_full); end
    af_thresh = 5'd12;
    #1;
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af_thr12: got %b want 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_udf: got %b want 0", underflow); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_release_empty: got %b want 1", empty); end
  endtask

  task automatic test_fill_overflow();
    af_thresh = 5'd16; ae_thresh = 5'd0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i + 1));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (depth !== 5'd16) begin errors++; $display("FAIL fill_depth: got %0d want 16", depth); end
    checks++; if (data_out !== 16'h0001) begin errors++; $display("FAIL fill_head: got %h want 0001", data_out); end
    step(1'b1, 1'b0, 16'hDEAD);
    checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag: got %b want %b", overflow, ERR_EN); end
    checks++; if (depth !== 5'd16) begin errors++; $display("FAIL ovf_depth: got %0d want 16", depth); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data_out !== DW'(i + 1)) begin
        errors++; $display("FAIL ovf_readback[%0d]: got %h want %h", i, data_out, DW'(i + 1));
      end
      step(1'b0, 1'b1, '0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty: got %b want 1", empty); end
    checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_sticky: got %b want %b", overflow, ERR_EN); end
    err_clr = 1'b1;
    step(1'b0, 1'b0, '0);
    err_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_write_through_full();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i + 1));
    step(1'b1, 1'b1, 16'hBEEF);
    checks++; if (depth !== 5'd16) begin errors++; $display("FAIL wt_depth: got %0d want 16", depth); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL wt_full: got %b want 1", full); end
    checks++; if (data_out !== 16'h0002) begin errors++; $display("FAIL wt_head: got %h want 0002", data_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wt_no_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] exp_d;
      exp_d = (i == 15) ? 16'hBEEF : DW'(i + 2);
      checks++;
      if (data_out !== exp_d) begin
        errors++; $display("FAIL wt_readback[%0d]: got %h want %h", i, data_out, exp_d);
      end
      step(1'b0, 1'b1, '0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wt_drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, '0);
    checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL udf_flag: got %b want %b", underflow, ERR_EN); end
    checks++; if (depth !== 5'd0) begin errors++; $display("FAIL udf_depth: got %0d want 0", depth); end
    err_clr = 1'b1;
    step(1'b0, 1'b0, '0);
    err_clr = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b want 0", underflow); end
    // clear and a fresh event in the same cycle: the event wins
    err_clr = 1'b1;
    step(1'b0, 1'b1, '0);
    err_clr = 1'b0;
    checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL udf_set_wins: got %b want %b", underflow, ERR_EN); end
    err_clr = 1'b1;
    step(1'b0, 1'b0, '0);
    err_clr = 1'b0;
    // read on empty with same-cycle write: write lands, read is rejected
    step(1'b1, 1'b1, 16'h00A5);
    checks++; if (depth !== 5'd1) begin errors++; $display("FAIL nobypass_depth: got %0d want 1", depth); end
    checks++; if (data_out !== 16'h00A5) begin errors++; $display("FAIL nobypass_head: got %h want 00a5", data_out); end
    checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL nobypass_udf: got %b want %b", underflow, ERR_EN); end
    // valid read together with clear: flag drops
    err_clr = 1'b1;
    step(1'b0, 1'b1, '0);
    err_clr = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL udf_final_empty: got %b want 1", empty); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_final_clear: got %b want 0", underflow); end
  endtask

  task automatic test_thresholds();
    af_thresh = 5'd12; ae_thresh = 5'd3;
    #1;
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL thr_ae0: got %b want 1", almost_empty); end
    for (int k = 1; k <= 12; k++) begin
      logic exp_af;
      exp_af = (k >= 12);
      step(1'b1, 1'b0, DW'(16'h0C00 + k));
      checks++;
      if (almost_full !== exp_af) begin
        errors++; $display("FAIL thr_af_at_%0d: got %b want %b", k, almost_full, exp_af);
      end
    end
    ae_thresh = 5'd16;
    #1;
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL thr_ae_force: got %b want 1", almost_empty); end
    af_thresh = 5'd13;
    #1;
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL thr_af_live: got %b want 0", almost_full); end
    af_thresh = 5'd12; ae_thresh = 5'd3;
    for (int d = 11; d >= 0; d--) begin
      logic exp_ae;
      exp_ae = (d <= 3);
      step(1'b0, 1'b1, '0);
      checks++;
      if (almost_empty !== exp_ae || depth !== 5'(d)) begin
        errors++; $display("FAIL thr_ae_at_%0d: got ae=%b depth=%0d want ae=%b depth=%0d", d, almost_empty, depth, exp_ae, d);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    int            wpct;
    int            rpct;
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic          rq;
    logic          wq;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      case (cyc / 250)
        0:       begin wpct = 75; rpct = 25; end
        1:       begin wpct = 25; rpct = 75; end
        2:       begin wpct = 50; rpct = 50; end
        default: begin wpct = 90; rpct = 50; end
      endcase
      w  = ($urandom_range(0, 99) < wpct);
      r  = ($urandom_range(0, 99) < rpct);
      d  = DW'($urandom);
      rq = r && (q.size() != 0);
      wq = w && ((q.size() != 16) || rq);
      if (rq) void'(q.pop_front());
      if (wq) q.push_back(d);
      step(w, r, d);
      checks++;
      if (depth !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 16)) begin
        errors++;
        $display("FAIL rand_status cyc %0d: got depth=%0d empty=%b full=%b want depth=%0d", cyc, depth, empty, full, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (data_out !== q[0]) begin
          errors++; $display("FAIL rand_data cyc %0d: got %h want %h", cyc, data_out, q[0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 40 && !empty; n++) step(1'b0, 1'b1, '0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_predrain: got %b want 1", empty); end
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, DW'(16'h0900 + k));
    checks++; if (depth !== 5'd9) begin errors++; $display("FAIL arst_pre_depth: got %0d want 9", depth); end
    wen = 1'b1; data_in = 16'h7777;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (depth !== 5'd0) begin errors++; $display("FAIL arst_depth: got %0d want 0", depth); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", empty); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL arst_err: got %b%b want 00", overflow, underflow); end
    @(posedge clk);
    #1;
    wen = 1'b0;
    checks++; if (depth !== 5'd0) begin errors++; $display("FAIL arst_hold: got %0d want 0", depth); end
    #3;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 16'h4321);
    checks++; if (depth !== 5'd1) begin errors++; $display("FAIL arst_new_depth: got %0d want 1", depth); end
    checks++; if (data_out !== 16'h4321) begin errors++; $display("FAIL arst_new_data: got %h want 4321", data_out); end
    step(1'b0, 1'b1, '0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_new_drain: got %b want 1", empty); end
  endtask

  initial begin
    reset_n = 1'b0; wen = 1'b0; ren = 1'b0; err_clr = 1'b0;
    data_in = '0; af_thresh = '0; ae_thresh = '0;
    #12;
    test_reset();
    test_fill_overflow();
    test_write_through_full();
    test_underflow();
    test_thresholds();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
